// File: rtl/nec_bus_ctrl.sv
// NEC V30/V35 bus controller: generates CPU clock/reset and bridges CPU bus
// cycles onto a valid/ready local request port, holding READY low until done.
module nec_bus_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int RESET_HOLD = 16,
    parameter int WAIT_MIN   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        nec_clk,
    output logic        nec_reset,
    output logic        nec_ready,
    input  logic [19:0] nec_ad_i,
    output logic [15:0] nec_ad_o,
    output logic        nec_ad_oe,
    input  logic        nec_astb,
    input  logic        nec_rdn,
    input  logic        nec_wrn,
    input  logic        nec_ion,
    input  logic        nec_uben,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic        req_io,
    output logic [19:0] req_addr,
    output logic [1:0]  req_be,
    output logic [15:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic        timeout_err
);

    localparam int DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int RW   = $clog2(RESET_HOLD + 2);
    localparam int WW   = $clog2(WAIT_MIN + 2);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          nec_clk_q, nec_clk_d;
    logic [RW-1:0] rh_q, rh_d;
    logic          nec_reset_q, nec_reset_d;
    logic          nec_ready_q, nec_ready_d;
    logic          astb_prev_q;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          req_valid_q, req_valid_d;
    logic          req_write_q, req_write_d;
    logic          req_io_q, req_io_d;
    logic [19:0]   req_addr_q, req_addr_d;
    logic [1:0]    req_be_q, req_be_d;
    logic [15:0]   req_wdata_q, req_wdata_d;
    logic [15:0]   ad_o_q, ad_o_d;
    logic          ad_oe_q, ad_oe_d;
    logic          timeout_err_q, timeout_err_d;

    logic fall_ph;
    logic astb_fall;
    logic wait_done;
    logic tmo_hit;

    assign fall_ph   = (div_q == {DW{1'b0}});
    assign astb_fall = astb_prev_q & ~nec_astb;
    assign wait_done = (wait_cnt_q >= WW'(WAIT_MIN));
    assign tmo_hit   = (TIMEOUT != 0) && (tcnt_q == TW'(TMAX));

    // Clock divider and CPU reset hold-off after system reset release.
    always_comb begin
        div_d       = (div_q == DW'(CLK_DIV - 1)) ? {DW{1'b0}} : div_q + DW'(1);
        nec_clk_d   = (div_d >= DW'(CLK_DIV / 2));
        rh_d        = rh_q;
        nec_reset_d = nec_reset_q;
        if (nec_reset_q && fall_ph) begin
            if ((rh_q + RW'(1)) >= RW'(RESET_HOLD)) begin
                nec_reset_d = 1'b0;
            end else begin
                rh_d = rh_q + RW'(1);
            end
        end else begin
            rh_d = rh_q;
        end
    end

    // Bus-cycle FSM: next state, request latching, READY and read-data control.
    always_comb begin
        state_d       = state_q;
        nec_ready_d   = nec_ready_q;
        wait_cnt_d    = wait_cnt_q;
        tcnt_d        = tcnt_q;
        req_valid_d   = req_valid_q;
        req_write_d   = req_write_q;
        req_io_d      = req_io_q;
        req_addr_d    = req_addr_q;
        req_be_d      = req_be_q;
        req_wdata_d   = req_wdata_q;
        ad_o_d        = ad_o_q;
        ad_oe_d       = nec_rdn ? 1'b0 : ad_oe_q;
        timeout_err_d = 1'b0;

        // Minimum wait states are counted in NEC clocks from the ASTB fall.
        if (state_q != S_IDLE && fall_ph && !wait_done) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!nec_reset_q && astb_fall) begin
                    req_addr_d  = nec_ad_i;
                    req_io_d    = ~nec_ion;
                    req_be_d    = {~nec_uben, ~nec_ad_i[0]};
                    nec_ready_d = 1'b0;
                    wait_cnt_d  = {WW{1'b0}};
                    state_d     = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (!nec_rdn) begin
                    req_write_d = 1'b0;
                    req_valid_d = 1'b1;
                    state_d     = S_REQ;
                end else if (!nec_wrn) begin
                    req_wdata_d = nec_ad_i[15:0];
                    req_write_d = 1'b1;
                    req_valid_d = 1'b1;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    tcnt_d      = {TW{1'b0}};
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (rsp_valid) begin
                    ad_o_d  = req_write_q ? ad_o_q : rsp_rdata;
                    ad_oe_d = ~req_write_q & ~nec_rdn;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    ad_o_d        = req_write_q ? ad_o_q : 16'hFFFF;
                    ad_oe_d       = ~req_write_q & ~nec_rdn;
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DONE: begin
                if (wait_done && fall_ph && !nec_ready_q) begin
                    nec_ready_d = 1'b1;
                end else begin
                    nec_ready_d = nec_ready_q;
                end
                if (nec_ready_q && nec_rdn && nec_wrn) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
                nec_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= {DW{1'b0}};
            nec_clk_q     <= 1'b0;
            rh_q          <= {RW{1'b0}};
            nec_reset_q   <= 1'b1;
            nec_ready_q   <= 1'b1;
            astb_prev_q   <= 1'b0;
            wait_cnt_q    <= {WW{1'b0}};
            tcnt_q        <= {TW{1'b0}};
            req_valid_q   <= 1'b0;
            req_write_q   <= 1'b0;
            req_io_q      <= 1'b0;
            req_addr_q    <= 20'h00000;
            req_be_q      <= 2'b00;
            req_wdata_q   <= 16'h0000;
            ad_o_q        <= 16'h0000;
            ad_oe_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            nec_clk_q     <= nec_clk_d;
            rh_q          <= rh_d;
            nec_reset_q   <= nec_reset_d;
            nec_ready_q   <= nec_ready_d;
            astb_prev_q   <= nec_astb;
            wait_cnt_q    <= wait_cnt_d;
            tcnt_q        <= tcnt_d;
            req_valid_q   <= req_valid_d;
            req_write_q   <= req_write_d;
            req_io_q      <= req_io_d;
            req_addr_q    <= req_addr_d;
            req_be_q      <= req_be_d;
            req_wdata_q   <= req_wdata_d;
            ad_o_q        <= ad_o_d;
            ad_oe_q       <= ad_oe_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign nec_clk     = nec_clk_q;
    assign nec_reset   = nec_reset_q;
    assign nec_ready   = nec_ready_q;
    assign nec_ad_o    = ad_o_q;
    assign nec_ad_oe   = ad_oe_q;
    assign req_valid   = req_valid_q;
    assign req_write   = req_write_q;
    assign req_io      = req_io_q;
    assign req_addr    = req_addr_q;
    assign req_be      = req_be_q;
    assign req_wdata   = req_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// Self-checking bench for nec_bus_ctrl: drives CPU bus cycles and a local
// responder, with expected requests and read data held in scoreboard queues.
module tb_nec_bus_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        nec_clk, nec_reset, nec_ready, nec_ad_oe;
    logic [19:0] nec_ad_i = 20'h00000;
    logic [15:0] nec_ad_o;
    logic        nec_astb = 1'b1;
    logic        nec_rdn = 1'b1;
    logic        nec_wrn = 1'b1;
    logic        nec_ion = 1'b1;
    logic        nec_uben = 1'b1;
    logic        req_valid, req_write, req_io;
    logic        req_ready = 1'b0;
    logic [19:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_rdata = 16'h0000;
    logic        timeout_err;

    typedef struct packed {
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [15:0] rd_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int tb_div = 0;

    nec_bus_ctrl #(.CLK_DIV(4), .RESET_HOLD(2), .WAIT_MIN(0), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .nec_clk(nec_clk), .nec_reset(nec_reset), .nec_ready(nec_ready),
        .nec_ad_i(nec_ad_i), .nec_ad_o(nec_ad_o), .nec_ad_oe(nec_ad_oe),
        .nec_astb(nec_astb), .nec_rdn(nec_rdn), .nec_wrn(nec_wrn),
        .nec_ion(nec_ion), .nec_uben(nec_uben),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Handshake counter, used to prove exactly one accept per bus cycle.
    always @(posedge clk) begin
        if (req_valid && req_ready) n_acc <= n_acc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tb_div = (tb_div + 1) % 4;
    endtask

    task automatic check_req(input req_t e);
        check_val("req_write", 32'(req_write), 32'(e.wr));
        check_val("req_io", 32'(req_io), 32'(e.io));
        check_val("req_addr", 32'(req_addr), 32'(e.addr));
        check_val("req_be", 32'(req_be), 32'(e.be));
        if (e.wr) check_val("req_wdata", 32'(req_wdata), 32'(e.wdata));
    endtask

    // One CPU bus cycle; rsp_at = clk index after accept carrying rsp_valid (0 = never).
    task automatic bus_cycle(input bit wr, input bit io, input logic [19:0] addr,
                             input logic [15:0] data, input bit uben, input int stall,
                             input int rsp_at, input logic [15:0] rdata);
        req_t e;
        int   acc0;
        bit   done;
        bit   rdy;
        bit   fp;
        bit   to_exp;
        nec_ad_i = addr;
        nec_ion  = ~io;
        nec_uben = uben;
        nec_astb = 1'b1;
        tick();
        e.wr = wr; e.io = io; e.addr = addr;
        e.be = {~uben, ~addr[0]}; e.wdata = data;
        req_q.push_back(e);
        nec_astb = 1'b0;
        tick();
        check_val("ready_drop", 32'(nec_ready), 32'(0));
        nec_ad_i = {4'h0, data};
        if (wr) nec_wrn = 1'b0;
        else    nec_rdn = 1'b0;
        tick();
        for (int i = 0; i < stall; i++) begin
            check_val("stall_valid", 32'(req_valid), 32'(1));
            check_req(req_q[0]);
            check_val("stall_ready", 32'(nec_ready), 32'(0));
            tick();
        end
        req_ready = 1'b1;
        check_val("acc_valid", 32'(req_valid), 32'(1));
        check_req(req_q.pop_front());
        acc0 = n_acc;
        tick();
        req_ready = 1'b0;
        check_val("one_accept", 32'(n_acc - acc0), 32'(1));
        if (!wr) rd_q.push_back((rsp_at > 0 && rsp_at <= TO) ? rdata : 16'hFFFF);
        done = 1'b0;
        rdy  = 1'b0;
        for (int k = 1; k <= TO + 5; k++) begin
            rsp_valid = (k == rsp_at);
            rsp_rdata = (k == rsp_at) ? rdata : 16'h0000;
            fp = (tb_div == 0);
            if (done && fp) rdy = 1'b1;
            to_exp = (k == TO) && !done && (k != rsp_at);
            tick();
            if (!done && (k == rsp_at || k == TO)) done = 1'b1;
            check_val("timeout_err", 32'(timeout_err), 32'(to_exp));
            check_val("ready_wait", 32'(nec_ready), 32'(rdy));
            check_val("valid_low", 32'(req_valid), 32'(0));
        end
        rsp_valid = 1'b0;
        if (!wr) begin
            check_val("rd_oe", 32'(nec_ad_oe), 32'(1));
            check_val("rd_data", 32'(nec_ad_o), 32'(rd_q.pop_front()));
        end else begin
            check_val("wr_oe", 32'(nec_ad_oe), 32'(0));
        end
        nec_rdn  = 1'b1;
        nec_wrn  = 1'b1;
        nec_astb = 1'b1;
        tick();
        check_val("oe_release", 32'(nec_ad_oe), 32'(0));
        tick();
    endtask

    task automatic release_reset();
        reset  = 1'b0;
        tb_div = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val("nec_clk", 32'(nec_clk), 32'(tb_div >= 2));
            check_val("nec_reset", 32'(nec_reset), 32'(i < 5));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_nec_reset", 32'(nec_reset), 32'(1));
        check_val("rst_nec_ready", 32'(nec_ready), 32'(1));
        check_val("rst_nec_clk", 32'(nec_clk), 32'(0));
        check_val("rst_req_valid", 32'(req_valid), 32'(0));
        check_val("rst_oe", 32'(nec_ad_oe), 32'(0));
        release_reset();

        bus_cycle(1'b0, 1'b0, 20'h12345, 16'h0000, 1'b0, 0, 2, 16'hBEEF);
        bus_cycle(1'b1, 1'b1, 20'h00040, 16'h00A5, 1'b1, 0, 1, 16'h0000);
        bus_cycle(1'b0, 1'b0, 20'h0ABCD, 16'h0000, 1'b0, 10, 3, 16'h1234);
        bus_cycle(1'b0, 1'b0, 20'h00100, 16'h0000, 1'b0, 0, 0, 16'h0000);
        bus_cycle(1'b0, 1'b0, 20'h00102, 16'h0000, 1'b0, 0, TO, 16'h5A5A);

        // Reset asserted while a request is pending.
        nec_ad_i = 20'h54321;
        nec_astb = 1'b1;
        tick();
        nec_astb = 1'b0;
        tick();
        nec_rdn = 1'b0;
        tick();
        check_val("req_pending", 32'(req_valid), 32'(1));
        #1;
        reset = 1'b1;
        #1;
        check_val("async_valid", 32'(req_valid), 32'(0));
        check_val("async_ready", 32'(nec_ready), 32'(1));
        check_val("async_nec_reset", 32'(nec_reset), 32'(1));
        check_val("async_addr", 32'(req_addr), 32'(0));
        nec_rdn  = 1'b1;
        nec_astb = 1'b1;
        @(posedge clk);
        #1;
        release_reset();
        check_val("post_rst_valid", 32'(req_valid), 32'(0));
        bus_cycle(1'b0, 1'b0, 20'hFFFFF, 16'h0000, 1'b1, 0, 1, 16'hC3C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
